// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states
// and the byte-lane mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Unshifted byte-enable pattern for an access size; illegal selects no lanes.
  function automatic logic [3:0] size_mask(input size_e size);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'h1;
      SZ_HALF: mask = 4'h3;
      SZ_WORD: mask = 4'hF;
      default: mask = 4'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane shifter: positions store data / byte enables across a
// two-word window and extracts and extends load data from that window.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  output logic [6:0]  be7,
  output logic [63:0] wdata64,
  output logic [31:0] rdata
);

  logic [5:0]  shamt;
  logic [63:0] rshift;

  assign shamt = {off, 3'b000};

  // Lane placement for stores and right-justify plus extension for loads.
  always_comb begin
    be7     = {3'b000, size_mask(size_e'(size))} << off;
    wdata64 = {32'h0, wdata} << shamt;
    rshift  = rbuf >> shamt;
    rdata   = '0;
    case (size_e'(size))
      SZ_BYTE: rdata = {{24{~is_unsigned & rshift[7]}}, rshift[7:0]};
      SZ_HALF: rdata = {{16{~is_unsigned & rshift[15]}}, rshift[15:0]};
      SZ_WORD: rdata = rshift[31:0];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, unaligned accesses split into two
// word beats, loads assembled from a two-word buffer, held response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                  state, state_nxt;
  logic                    we_q, uns_q;
  size_e                   size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [63:0]             rbuf_q;

  logic [6:0]              be7;
  logic [63:0]             wdata64;
  logic [31:0]             rdata_ext;
  logic [ADDR_WIDTH-1:0]   lo_addr, hi_addr;
  logic                    split, accept;

  lsu_align u_align (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rbuf        (rbuf_q),
    .be7         (be7),
    .wdata64     (wdata64),
    .rdata       (rdata_ext)
  );

  assign lo_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign hi_addr = lo_addr + ADDR_WIDTH'(4);
  assign split   = |be7[6:4];
  assign accept  = (state == ST_IDLE) && req_valid_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Request capture and load-beat buffering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= size_e'(req_size_i);
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rbuf_q  <= '0;
      end
      if (state == ST_ACC_LO && !we_q) rbuf_q[31:0]  <= mem_rdata_i;
      if (state == ST_ACC_HI && !we_q) rbuf_q[63:32] <= mem_rdata_i;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          state_nxt = (size_e'(req_size_i) == SZ_ILLEGAL) ? ST_RESP : ST_ACC_LO;
      end
      ST_ACC_LO: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = lo_addr;
        mem_wdata_o = wdata64[31:0];
        mem_be_o    = be7[3:0];
        state_nxt   = split ? ST_ACC_HI : ST_RESP;
      end
      ST_ACC_HI: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = hi_addr;
        mem_wdata_o = wdata64[63:32];
        mem_be_o    = {1'b0, be7[6:4]};
        state_nxt   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = (size_q == SZ_ILLEGAL);
        if (!we_q && size_q != SZ_ILLEGAL) resp_rdata_o = rdata_ext;
        if (resp_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Outputs are forced idle while reset is asserted, so an access aborted
    // in ACC_HI never presents its second beat to the RAM at the reset edge.
    if (rst_i) begin
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
      mem_en_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_be_o     = '0;
    end
  end

endmodule
